// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial bit feeder.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

  // Bit_Cnt must be able to encode WIDTH itself (parity slot).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register. bit_out is the head bit the register
// will hold after the coming edge, so the caller can register it directly.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             bit_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // Next contents: load wins over shift; otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end else begin
      sr_d = sr_q;
    end
  end

  assign bit_out = (MSB_FIRST != 0) ? sr_d[WIDTH-1] : sr_d[0];

  // Shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Word serializer with valid/ready input and registered bit stream output.
// Define SERIAL_BIT_FEEDER_PARITY_EN to append an even-parity bit per word.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [WIDTH-1:0]                Din,
  input  logic                            Din_Valid,
  output logic                            Din_Ready,
  input  logic                            Stall,
  output logic                            Bit_Out,
  output logic                            Bit_Valid,
  output logic                            Last,
  output logic [cnt_width(WIDTH)-1:0]     Bit_Cnt,
  output logic                            Busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam bit            HAS_PAR  = 1'b1;
`else
  localparam bit            HAS_PAR  = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_out_q, bit_out_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          load_s, shift_s, par_sel_s, head_s, par_s;
  logic          ready_s, accept_s, at_last_s;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk      (Clk),
    .rst      (Rst),
    .load     (load_s),
    .shift_en (shift_s),
    .din      (Din),
    .bit_out  (head_s)
  );

  assign at_last_s = (state_q == SHIFT) && (cnt_q == LAST_IDX);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  logic par_q;
  assign ready_s = (state_q == IDLE) || (state_q == PAR);
  assign par_s   = par_q;

  // Parity of the word, captured alongside the data.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      par_q <= 1'b0;
    end else if (load_s) begin
      par_q <= ^Din;
    end else begin
      par_q <= par_q;
    end
  end
`else
  assign ready_s = (state_q == IDLE) || at_last_s;
  assign par_s   = 1'b0;
`endif

  assign Din_Ready = !Rst && !Stall && ready_s;
  assign accept_s  = Din_Valid && Din_Ready;

  // FSM next state, counter and next output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    par_sel_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept_s) begin
          state_d = SHIFT;
          load_s  = 1'b1;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (Stall) begin
          state_d = SHIFT;
        end else if (!at_last_s) begin
          shift_s = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          valid_d = 1'b1;
          last_d  = !HAS_PAR && ((cnt_q + CW'(1)) == LAST_IDX);
        end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        else begin
          state_d   = PAR;
          cnt_d     = CW'(WIDTH);
          valid_d   = 1'b1;
          last_d    = 1'b1;
          par_sel_s = 1'b1;
        end
`else
        else if (accept_s) begin
          load_s  = 1'b1;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
      end
      PAR: begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        if (Stall) begin
          state_d = PAR;
        end else if (accept_s) begin
          state_d = SHIFT;
          load_s  = 1'b1;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`else
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!valid_d) begin
      bit_out_d = IDLE_LEVEL;
    end else if (par_sel_s) begin
      bit_out_d = par_s;
    end else begin
      bit_out_d = head_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_out_q <= IDLE_LEVEL;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_out_q <= bit_out_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign Bit_Out   = bit_out_q;
  assign Bit_Valid = valid_q;
  assign Last      = last_q;
  assign Bit_Cnt   = cnt_q;
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed self-checking bench for serial_bit_feeder (MSB-first and LSB-first instances).
module tb_serial_bit_feeder;

  localparam int W = 8;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] Din;
  logic       Din_Valid;
  logic       Stall;

  logic       m_ready, m_bit, m_valid, m_last, m_busy;
  logic [3:0] m_cnt;
  logic       l_ready, l_bit, l_valid, l_last, l_busy;
  logic [3:0] l_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Din_Valid(Din_Valid), .Din_Ready(m_ready),
    .Stall(Stall), .Bit_Out(m_bit), .Bit_Valid(m_valid), .Last(m_last),
    .Bit_Cnt(m_cnt), .Busy(m_busy)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .Clk(Clk), .Rst(Rst), .Din(Din), .Din_Valid(Din_Valid), .Din_Ready(l_ready),
    .Stall(Stall), .Bit_Out(l_bit), .Bit_Valid(l_valid), .Last(l_last),
    .Bit_Cnt(l_cnt), .Busy(l_busy)
  );

  // Expected k-th frame bit of word w (index W is the even-parity bit).
  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
    if (k >= W) return ^w;
    return msb ? w[W-1-k] : w[k];
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Din = 8'hFF; Din_Valid = 1'b1; Stall = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", m_valid); end
    checks++; if (m_bit !== 1'b0) begin fails++; $display("FAIL reset_bit got %b want 0", m_bit); end
    checks++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", m_last); end
    checks++; if (m_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", m_cnt); end
    checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", m_busy); end
    Rst = 1'b0; Din_Valid = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got %b want 1", m_ready); end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic       e;
    w = 8'hA5;
    next_cycle();
    Din = w; Din_Valid = 1'b1; Stall = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", m_ready); end
    next_cycle();
    Din_Valid = 1'b0; Din = 8'h00;
    #1;
    for (int k = 0; k < FL; k++) begin
      e = exp_bit(w, k, 1'b1);
      checks++; if (m_valid !== 1'b1) begin fails++; $display("FAIL single_valid k=%0d got %b want 1", k, m_valid); end
      checks++; if (m_bit !== e) begin fails++; $display("FAIL single_bit k=%0d got %b want %b", k, m_bit, e); end
      checks++; if (m_last !== (k == FL - 1)) begin fails++; $display("FAIL single_last k=%0d got %b want %b", k, m_last, (k == FL - 1)); end
      checks++; if (m_cnt !== 4'(k)) begin fails++; $display("FAIL single_cnt k=%0d got %0d want %0d", k, m_cnt, k); end
      checks++; if (m_busy !== 1'b1) begin fails++; $display("FAIL single_busy k=%0d got %b want 1", k, m_busy); end
      next_cycle();
    end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL single_end_valid got %b want 0", m_valid); end
    checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL single_end_busy got %b want 0", m_busy); end
    checks++; if (m_bit !== 1'b0) begin fails++; $display("FAIL single_end_bit got %b want 0", m_bit); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic       e;
    int         k;
    next_cycle();
    Din = 8'hA5; Din_Valid = 1'b1; Stall = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready0 got %b want 1", m_ready); end
    for (int c = 1; c <= 2 * FL; c++) begin
      next_cycle();
      Din = 8'h5A; Din_Valid = (c <= FL);
      #1;
      w = (c > FL) ? 8'h5A : 8'hA5;
      k = (c - 1) % FL;
      e = exp_bit(w, k, 1'b1);
      if (c < 2 * FL) begin
        checks++; if (m_ready !== (c == FL)) begin fails++; $display("FAIL b2b_ready c=%0d got %b want %b", c, m_ready, (c == FL)); end
      end
      checks++; if (m_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid c=%0d got %b want 1", c, m_valid); end
      checks++; if (m_bit !== e) begin fails++; $display("FAIL b2b_bit c=%0d got %b want %b", c, m_bit, e); end
      checks++; if (m_last !== (k == FL - 1)) begin fails++; $display("FAIL b2b_last c=%0d got %b want %b", c, m_last, (k == FL - 1)); end
    end
    next_cycle();
    Din_Valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL b2b_end_valid got %b want 0", m_valid); end
    checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL b2b_end_busy got %b want 0", m_busy); end
  endtask

  task automatic test_stall();
    logic [15:0] got;
    logic        ev;
    int          n;
    got = 16'h0000;
    n   = 0;
    next_cycle();
    Din = 8'hF0; Din_Valid = 1'b1; Stall = 1'b0;
    #1;
    for (int c = 1; c <= FL + 3; c++) begin
      next_cycle();
      Stall = (c == 3) || (c == 4);
      Din_Valid = Stall;
      Din = 8'hFF;
      #1;
      if (c == 3 || c == 4) begin
        checks++; if (m_ready !== 1'b0) begin fails++; $display("FAIL stall_ready c=%0d got %b want 0", c, m_ready); end
      end
      ev = !(c == 4 || c == 5) && (c <= FL + 2);
      checks++; if (m_valid !== ev) begin fails++; $display("FAIL stall_valid c=%0d got %b want %b", c, m_valid, ev); end
      if (c == 5) begin
        checks++; if (m_cnt !== 4'd2) begin fails++; $display("FAIL stall_cnt_hold got %0d want 2", m_cnt); end
        checks++; if (m_bit !== 1'b0) begin fails++; $display("FAIL stall_idle_bit got %b want 0", m_bit); end
      end
      if (c == FL + 3) begin
        checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL stall_end_busy got %b want 0", m_busy); end
      end
      if (m_valid === 1'b1) begin
        if (n < 16) got[n] = m_bit;
        n++;
      end
    end
    Stall = 1'b0; Din_Valid = 1'b0;
    checks++; if (n != FL) begin fails++; $display("FAIL stall_count got %0d want %0d", n, FL); end
    for (int k = 0; k < FL; k++) begin
      checks++; if (got[k] !== exp_bit(8'hF0, k, 1'b1)) begin fails++; $display("FAIL stall_seq k=%0d got %b want %b", k, got[k], exp_bit(8'hF0, k, 1'b1)); end
    end
  endtask

  task automatic test_reset_mid_word();
    next_cycle();
    Din = 8'hA5; Din_Valid = 1'b1; Stall = 1'b0;
    #1;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      Din_Valid = 1'b0;
      #1;
      checks++; if (m_bit !== exp_bit(8'hA5, c - 1, 1'b1)) begin fails++; $display("FAIL rstmid_pre c=%0d got %b want %b", c, m_bit, exp_bit(8'hA5, c - 1, 1'b1)); end
    end
    next_cycle();
    Rst = 1'b1;
    #1;
    next_cycle();
    Rst = 1'b0; Din = 8'h0F; Din_Valid = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", m_valid); end
    checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", m_busy); end
    checks++; if (m_cnt !== 4'd0) begin fails++; $display("FAIL rstmid_cnt got %0d want 0", m_cnt); end
    checks++; if (m_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got %b want 1", m_ready); end
    for (int k = 0; k < FL; k++) begin
      next_cycle();
      Din_Valid = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b1) begin fails++; $display("FAIL rstmid_new_valid k=%0d got %b want 1", k, m_valid); end
      checks++; if (m_bit !== exp_bit(8'h0F, k, 1'b1)) begin fails++; $display("FAIL rstmid_new_bit k=%0d got %b want %b", k, m_bit, exp_bit(8'h0F, k, 1'b1)); end
      checks++; if (m_cnt !== 4'(k)) begin fails++; $display("FAIL rstmid_new_cnt k=%0d got %0d want %0d", k, m_cnt, k); end
    end
    next_cycle();
    checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL rstmid_end_busy got %b want 0", m_busy); end
  endtask

  task automatic test_lsb_first();
    next_cycle();
    Din = 8'h01; Din_Valid = 1'b1; Stall = 1'b0;
    #1;
    for (int k = 0; k < FL; k++) begin
      next_cycle();
      Din_Valid = 1'b0;
      #1;
      checks++; if (l_valid !== 1'b1) begin fails++; $display("FAIL lsb_valid k=%0d got %b want 1", k, l_valid); end
      checks++; if (l_bit !== exp_bit(8'h01, k, 1'b0)) begin fails++; $display("FAIL lsb_bit k=%0d got %b want %b", k, l_bit, exp_bit(8'h01, k, 1'b0)); end
      checks++; if (l_last !== (k == FL - 1)) begin fails++; $display("FAIL lsb_last k=%0d got %b want %b", k, l_last, (k == FL - 1)); end
    end
    next_cycle();
    checks++; if (l_busy !== 1'b0) begin fails++; $display("FAIL lsb_end_busy got %b want 0", l_busy); end
  endtask

  task automatic test_stall_idle();
    next_cycle();
    Stall = 1'b1; Din = 8'hC3; Din_Valid = 1'b1;
    #1;
    checks++; if (m_ready !== 1'b0) begin fails++; $display("FAIL idle_stall_ready got %b want 0", m_ready); end
    next_cycle();
    Stall = 1'b0; Din_Valid = 1'b0;
    #1;
    checks++; if (m_busy !== 1'b0) begin fails++; $display("FAIL idle_stall_busy got %b want 0", m_busy); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL idle_stall_valid got %b want 0", m_valid); end
  endtask

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  task automatic test_parity();
    next_cycle();
    Din = 8'h07; Din_Valid = 1'b1; Stall = 1'b0;
    #1;
    for (int k = 0; k <= W; k++) begin
      next_cycle();
      Din_Valid = 1'b0;
      #1;
      if (k == W - 1) begin
        checks++; if (m_last !== 1'b0) begin fails++; $display("FAIL par_data_last got %b want 0", m_last); end
      end
    end
    checks++; if (m_bit !== 1'b1) begin fails++; $display("FAIL par_bit got %b want 1", m_bit); end
    checks++; if (m_valid !== 1'b1) begin fails++; $display("FAIL par_valid got %b want 1", m_valid); end
    checks++; if (m_last !== 1'b1) begin fails++; $display("FAIL par_last got %b want 1", m_last); end
    checks++; if (m_cnt !== 4'd8) begin fails++; $display("FAIL par_cnt got %0d want 8", m_cnt); end
    next_cycle();
  endtask
`endif

  initial begin
    Rst = 1'b1; Din = 8'h00; Din_Valid = 1'b0; Stall = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
    test_lsb_first();
    test_stall_idle();
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
